// File: rtl/dsha_work_dispatcher_pkg.sv
// Shared types and constants for the dsha work dispatcher: FSM encoding and nonce limits.
package dsha_work_dispatcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } disp_state_e;

   localparam logic [31:0] NONCE_MAX = 32'hFFFF_FFFF;

   localparam int DEF_PIPE_DEPTH = 3;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/dsha_work_dispatcher_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding winning nonces.
module dsha_work_dispatcher_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/dsha_work_dispatcher.sv
// Job holder and result checker for dsha_finisher: walks the nonce space of one job
// and queues nonces whose hash falls strictly below the target.
module dsha_work_dispatcher
   import dsha_work_dispatcher_pkg::*;
#(
   parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_mid,
   input  logic [95:0]  job_tail,
   input  logic [255:0] job_target,
   input  logic [31:0]  job_nstart,
   output logic [255:0] fin_X,
   output logic [95:0]  fin_Y,
   output logic [31:0]  fin_nonce,
   input  logic         fin_acc,
   input  logic [255:0] hash_in,
   input  logic [31:0]  nonce_in,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [31:0]  res_nonce,
   output logic         busy,
   output logic         done,
   output logic         overflow
);

   localparam int CW = $clog2(PIPE_DEPTH + 1);

   disp_state_e   state_q, state_d;
   logic [255:0]  x_q, x_d;
   logic [95:0]   y_q, y_d;
   logic [255:0]  target_q, target_d;
   logic [31:0]   nonce_q, nonce_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] drain_q, drain_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;
   logic          acc_d_q;
   logic          win;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;

   // Handshakes: a transfer happens on any clock where valid & ready are both high;
   // job_ready is constantly high so a new job always preempts the current one.
   assign job_ready = 1'b1;
   assign fifo_pop  = res_valid && res_ready;
   assign win       = (hash_in < target_q);

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      target_d  = target_q;
      nonce_d   = nonce_q;
      discard_d = discard_q;
      drain_d   = drain_q;
      done_d    = done_q;
      ovf_d     = ovf_q;
      fifo_push = 1'b0;

      if (job_valid) begin
         x_d       = job_mid;
         y_d       = job_tail;
         target_d  = job_target;
         nonce_d   = job_nstart;
         discard_d = CW'(PIPE_DEPTH);
         done_d    = 1'b0;
         ovf_d     = 1'b0;
         state_d   = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (fin_acc) begin
                  if (nonce_q == NONCE_MAX) begin
                     state_d = ST_DRAIN;
                     drain_d = CW'(PIPE_DEPTH);
                  end else begin
                     nonce_d = nonce_q + 32'd1;
                  end
               end
            end
            ST_DRAIN: begin
               if (fin_acc) begin
                  drain_d = drain_q - CW'(1);
                  if (drain_q == CW'(1)) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase

         // Results arriving in the first PIPE_DEPTH slots belong to an earlier job.
         if (acc_d_q && (state_q != ST_IDLE)) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else if (win) begin
               if (!fifo_full || fifo_pop) fifo_push = 1'b1;
               else                        ovf_d     = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         target_q  <= '0;
         nonce_q   <= '0;
         discard_q <= '0;
         drain_q   <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         acc_d_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         target_q  <= target_d;
         nonce_q   <= nonce_d;
         discard_q <= discard_d;
         drain_q   <= drain_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         acc_d_q   <= fin_acc;
      end
   end

   dsha_work_dispatcher_result_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (nonce_in),
      .pop_i   (fifo_pop),
      .rdata_o (res_nonce),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign fin_X     = x_q;
   assign fin_Y     = y_q;
   assign fin_nonce = nonce_q;
   assign res_valid = !fifo_empty;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_dsha_work_dispatcher.sv
// Directed self-checking bench for dsha_work_dispatcher.
module tb_dsha_work_dispatcher;

   logic         clk = 1'b0;
   logic         rst;
   logic         job_valid;
   logic         job_ready;
   logic [255:0] job_mid;
   logic [95:0]  job_tail;
   logic [255:0] job_target;
   logic [31:0]  job_nstart;
   logic [255:0] fin_X;
   logic [95:0]  fin_Y;
   logic [31:0]  fin_nonce;
   logic         fin_acc;
   logic [255:0] hash_in;
   logic [31:0]  nonce_in;
   logic         res_valid;
   logic         res_ready;
   logic [31:0]  res_nonce;
   logic         busy;
   logic         done;
   logic         overflow;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [255:0] ONES = {256{1'b1}};
   localparam logic [255:0] MID  = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5A5_5A5A_DEAD_BEEF_CAFE_F00D_1357_9BDF;
   localparam logic [95:0]  TAIL = 96'hAABB_CCDD_EEFF_0011_2233_4455;

   always #5 clk = ~clk;

   dsha_work_dispatcher dut (
      .clk        (clk),
      .rst        (rst),
      .job_valid  (job_valid),
      .job_ready  (job_ready),
      .job_mid    (job_mid),
      .job_tail   (job_tail),
      .job_target (job_target),
      .job_nstart (job_nstart),
      .fin_X      (fin_X),
      .fin_Y      (fin_Y),
      .fin_nonce  (fin_nonce),
      .fin_acc    (fin_acc),
      .hash_in    (hash_in),
      .nonce_in   (nonce_in),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_nonce  (res_nonce),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_job(input logic [255:0] tgt, input logic [31:0] nstart);
      @(negedge clk);
      job_valid  = 1'b1;
      job_mid    = MID;
      job_tail   = TAIL;
      job_target = tgt;
      job_nstart = nstart;
      @(negedge clk);
      job_valid  = 1'b0;
   endtask

   task automatic pulse(input logic [255:0] h, input logic [31:0] n);
      @(negedge clk);
      fin_acc  = 1'b1;
      hash_in  = h;
      nonce_in = n;
      @(negedge clk);
      fin_acc  = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      job_valid  = 1'b0;
      job_mid    = '0;
      job_tail   = '0;
      job_target = '0;
      job_nstart = '0;
      fin_acc    = 1'b0;
      hash_in    = '0;
      nonce_in   = '0;
      res_ready  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_job_ready", 256'(job_ready), 256'd1);
      check("rst_fin_X", fin_X, 256'd0);
      check("rst_fin_Y", 256'(fin_Y), 256'd0);
      check("rst_fin_nonce", 256'(fin_nonce), 256'd0);
      check("rst_res_valid", 256'(res_valid), 256'd0);
      check("rst_busy", 256'(busy), 256'd0);
      check("rst_done", 256'(done), 256'd0);
      check("rst_overflow", 256'(overflow), 256'd0);

      // 1: first three results discarded, fourth pushed
      send_job(ONES, 32'h10);
      check("t1_fin_X", fin_X, MID);
      check("t1_fin_Y", 256'(fin_Y), 256'(TAIL));
      check("t1_nonce0", 256'(fin_nonce), 256'h10);
      check("t1_busy", 256'(busy), 256'd1);
      pulse('0, 32'hAA);
      check("t1_nonce1", 256'(fin_nonce), 256'h11);
      check("t1_disc1", 256'(res_valid), 256'd0);
      pulse('0, 32'hAB);
      check("t1_nonce2", 256'(fin_nonce), 256'h12);
      check("t1_disc2", 256'(res_valid), 256'd0);
      pulse('0, 32'hAC);
      check("t1_disc3", 256'(res_valid), 256'd0);
      pulse(256'd5, 32'h10);
      check("t1_push_valid", 256'(res_valid), 256'd1);
      check("t1_push_nonce", 256'(res_nonce), 256'h10);
      check("t1_nonce4", 256'(fin_nonce), 256'h14);
      pop_one();
      check("t1_pop_empty", 256'(res_valid), 256'd0);

      // 2: compare boundaries
      send_job('0, 32'h100);
      repeat (3) pulse('0, 32'h1);
      pulse('0, 32'h100);
      check("t2_target0_nopush", 256'(res_valid), 256'd0);
      send_job(256'd1, 32'h200);
      repeat (3) pulse('0, 32'h1);
      pulse('0, 32'h200);
      check("t2_hash0_push", 256'(res_valid), 256'd1);
      check("t2_hash0_nonce", 256'(res_nonce), 256'h200);
      pulse(256'd1, 32'h201);
      pop_one();
      check("t2_equal_nopush", 256'(res_valid), 256'd0);

      // 3: end of nonce space
      send_job(ONES, 32'hFFFF_FFFE);
      check("t3_nonce_fe", 256'(fin_nonce), 256'hFFFF_FFFE);
      pulse(ONES, 32'h1);
      check("t3_nonce_ff", 256'(fin_nonce), 256'hFFFF_FFFF);
      pulse(ONES, 32'h2);
      check("t3_hold_ff", 256'(fin_nonce), 256'hFFFF_FFFF);
      check("t3_drain_busy", 256'(busy), 256'd1);
      check("t3_drain_notdone", 256'(done), 256'd0);
      pulse('0, 32'h3);
      pulse('0, 32'hFFFF_FFFE);
      check("t3_drain_push", 256'(res_valid), 256'd1);
      check("t3_drain_nonce", 256'(res_nonce), 256'hFFFF_FFFE);
      check("t3_still_busy", 256'(busy), 256'd1);
      pulse('0, 32'hFFFF_FFFF);
      check("t3_done", 256'(done), 256'd1);
      check("t3_idle", 256'(busy), 256'd0);
      check("t3_nowrap", 256'(fin_nonce), 256'hFFFF_FFFF);
      pop_one();
      check("t3_idle_ignored", 256'(res_valid), 256'd0);
      pulse('0, 32'h9);
      check("t3_idle_nonce", 256'(fin_nonce), 256'hFFFF_FFFF);
      check("t3_idle_empty", 256'(res_valid), 256'd0);
      check("t3_done_sticky", 256'(done), 256'd1);

      // 4: overflow with consumer stalled
      send_job(ONES, 32'h1000);
      check("t4_done_clr", 256'(done), 256'd0);
      repeat (3) pulse('0, 32'h1);
      for (int i = 0; i < 6; i++) pulse('0, 32'h1000 + 32'(i));
      check("t4_overflow", 256'(overflow), 256'd1);
      for (int i = 0; i < 4; i++) begin
         check("t4_pop_valid", 256'(res_valid), 256'd1);
         check("t4_pop_order", 256'(res_nonce), 256'h1000 + 256'(i));
         pop_one();
      end
      check("t4_drained", 256'(res_valid), 256'd0);

      // 5: job preempts on the same cycle as fin_acc
      pulse('0, 32'h1009);
      check("t5_pre_nonce", 256'(fin_nonce), 256'h100A);
      check("t5_pre_fifo", 256'(res_valid), 256'd1);
      @(negedge clk);
      job_valid  = 1'b1;
      job_target = ONES;
      job_nstart = 32'h5000;
      fin_acc    = 1'b1;
      hash_in    = '0;
      nonce_in   = 32'h7777;
      @(negedge clk);
      job_valid  = 1'b0;
      fin_acc    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t5_nonce_new", 256'(fin_nonce), 256'h5000);
      check("t5_ovf_clr", 256'(overflow), 256'd0);
      check("t5_done_clr", 256'(done), 256'd0);
      check("t5_fifo_kept", 256'(res_nonce), 256'h1009);
      pop_one();
      check("t5_no_stale_push", 256'(res_valid), 256'd0);
      pulse(ONES, 32'h1);
      check("t5_nonce_next", 256'(fin_nonce), 256'h5001);

      // 6: reset while draining with two queued winners
      send_job(ONES, 32'hFFFF_FFF0);
      repeat (3) pulse('0, 32'h1);
      pulse('0, 32'hFFFF_FFF0);
      pulse('0, 32'hFFFF_FFF1);
      check("t6_nonce", 256'(fin_nonce), 256'hFFFF_FFF5);
      repeat (11) pulse(ONES, 32'h2);
      check("t6_nonce_max", 256'(fin_nonce), 256'hFFFF_FFFF);
      pulse(ONES, 32'h3);
      check("t6_drain_busy", 256'(busy), 256'd1);
      check("t6_fifo_head", 256'(res_nonce), 256'hFFFF_FFF0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_rst_busy", 256'(busy), 256'd0);
      check("t6_rst_res_valid", 256'(res_valid), 256'd0);
      check("t6_rst_done", 256'(done), 256'd0);
      check("t6_rst_nonce", 256'(fin_nonce), 256'd0);
      check("t6_rst_fin_X", fin_X, 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
